// File: rtl/filter_pkg.sv
// Shared types for the filter pixel datapath: filter modes, pixel layout,
// the beat carried through the pipeline, and the BT.601-style luma sum.
package filter_pkg;

    localparam int PIXEL_W = 24;

    // Luma weights (sum to 256, so Y = sum[15:8] never overflows 8 bits)
    localparam logic [7:0] LUMA_R = 8'd77;
    localparam logic [7:0] LUMA_G = 8'd150;
    localparam logic [7:0] LUMA_B = 8'd29;

    typedef enum logic [1:0] {
        FILT_BYPASS = 2'd0,
        FILT_GRAY   = 2'd1,
        FILT_THRESH = 2'd2,
        FILT_INVERT = 2'd3
    } filter_mode_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // One input beat plus the filter settings it was accepted under
    typedef struct packed {
        pixel_t       pix;
        logic         user;
        logic         last;
        filter_mode_t mode;
        logic [7:0]   thr;
    } beat_t;

    function automatic logic [15:0] luma_sum(input pixel_t p);
        return 16'(p.r) * 16'(LUMA_R) + 16'(p.g) * 16'(LUMA_G) + 16'(p.b) * 16'(LUMA_B);
    endfunction

endpackage

// File: rtl/filter_skid_buffer.sv
// Generic 2-entry valid/ready register slice. in_ready_o comes straight
// from a flop, so there is no combinational path from out_ready_i.
module filter_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         main_vld_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         in_ready_q;   // high while the skid entry is empty
    logic         pop;

    // Main entry can take new data when it is empty or being drained
    assign pop         = out_ready_i || !main_vld_q;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_q;

    // Refill main from skid first; park an input beat in skid when main is stuck
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_vld_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else if (pop) begin
            if (!in_ready_q) begin
                main_q     <= skid_q;
                main_vld_q <= 1'b1;
                in_ready_q <= 1'b1;
            end else begin
                main_q     <= in_data_i;
                main_vld_q <= in_valid_i;
            end
        end else if (in_valid_i && in_ready_q) begin
            skid_q     <= in_data_i;
            in_ready_q <= 1'b0;
        end
    end

endmodule

// File: rtl/filter_pixel_core.sv
// AXI4-Stream pixel filter: bypass / grayscale / binary threshold / invert,
// two register stages (S1 luma sum, S2 filter select) plus frame/line status.
// Optional macro FILTER_PIXEL_SKID_EN inserts a 2-entry input skid buffer
// that registers s_axis_tready (latency 3 instead of 2).
module filter_pixel_core
    import filter_pkg::*;
#(
    parameter int         LINE_CNT_W     = 12,
    parameter int         FRAME_CNT_W    = 16,
    parameter logic [7:0] DEFAULT_THRESH = 8'h80
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [1:0]             cfg_mode,
    input  logic [7:0]             cfg_thresh,
    input  logic                   cfg_clr_err,
    input  logic [PIXEL_W-1:0]     s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tuser,
    input  logic                   s_axis_tlast,
    output logic [PIXEL_W-1:0]     m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tuser,
    output logic                   m_axis_tlast,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [LINE_CNT_W-1:0]  line_count,
    output logic                   sof_err
);

    beat_t                  in_beat, p_beat, s1_q;
    logic                   p_vld, ce, in_fire;
    logic [1:0]             vld_q;          // [0] = S1 valid, [1] = S2 valid
    filter_mode_t           mode_act_q;
    logic [7:0]             thr_act_q;
    logic [15:0]            sum_q;
    logic [7:0]             luma;
    logic [PIXEL_W-1:0]     out_data_q, out_data_d;
    logic                   out_user_q, out_last_q;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic [LINE_CNT_W-1:0]  line_q, line_d;
    logic                   sof_err_q, sof_err_d, prev_eol_q;

    assign ce      = !vld_q[1] || m_axis_tready;
    assign in_fire = s_axis_tvalid && s_axis_tready;

    // Tag each beat with its filter settings; a SOF beat takes cfg_* directly
    always_comb begin
        in_beat.pix  = pixel_t'(s_axis_tdata);
        in_beat.user = s_axis_tuser;
        in_beat.last = s_axis_tlast;
        in_beat.mode = s_axis_tuser ? filter_mode_t'(cfg_mode) : mode_act_q;
        in_beat.thr  = s_axis_tuser ? cfg_thresh : thr_act_q;
    end

`ifdef FILTER_PIXEL_SKID_EN
    filter_skid_buffer #(.W($bits(beat_t))) u_skid (
        .clk_i      (ACLK),
        .rst_i      (ARESET),
        .in_valid_i (s_axis_tvalid),
        .in_ready_o (s_axis_tready),
        .in_data_i  (in_beat),
        .out_valid_o(p_vld),
        .out_ready_i(ce),
        .out_data_o (p_beat)
    );
`else
    assign s_axis_tready = ce;
    assign p_vld         = s_axis_tvalid;
    assign p_beat        = in_beat;
`endif

    // Shadow config: only a SOF acceptance changes the active settings
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            mode_act_q <= FILT_BYPASS;
            thr_act_q  <= DEFAULT_THRESH;
        end else if (in_fire && s_axis_tuser) begin
            mode_act_q <= in_beat.mode;
            thr_act_q  <= in_beat.thr;
        end
    end

    // S2 filter select on the truncated luma
    assign luma = 8'(sum_q >> 8);

    always_comb begin
        out_data_d = s1_q.pix;
        case (s1_q.mode)
            FILT_GRAY:   out_data_d = {luma, luma, luma};
            FILT_THRESH: out_data_d = (luma >= s1_q.thr) ? {PIXEL_W{1'b1}} : {PIXEL_W{1'b0}};
            FILT_INVERT: out_data_d = ~s1_q.pix;
            default:     out_data_d = s1_q.pix;
        endcase
    end

    // Two-stage pipeline advancing on the global ce; stall holds everything
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            vld_q      <= '0;
            s1_q       <= '0;
            sum_q      <= '0;
            out_data_q <= '0;
            out_user_q <= 1'b0;
            out_last_q <= 1'b0;
        end else if (ce) begin
            vld_q      <= {vld_q[0], p_vld};
            s1_q       <= p_beat;
            sum_q      <= luma_sum(p_beat.pix);
            out_data_q <= out_data_d;
            out_user_q <= s1_q.user;
            out_last_q <= s1_q.last;
        end
    end

    assign m_axis_tvalid = vld_q[1];
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tuser  = out_user_q;
    assign m_axis_tlast  = out_last_q;

    // Status next-state: a new mid-line SOF error beats a same-cycle clear
    always_comb begin
        frame_d   = frame_q;
        line_d    = line_q;
        sof_err_d = cfg_clr_err ? 1'b0 : sof_err_q;
        if (in_fire) begin
            if (s_axis_tuser) begin
                frame_d = frame_q + FRAME_CNT_W'(1);
                line_d  = s_axis_tlast ? LINE_CNT_W'(1) : '0;
                if (!prev_eol_q) sof_err_d = 1'b1;
            end else if (s_axis_tlast && line_q != {LINE_CNT_W{1'b1}}) begin
                line_d = line_q + LINE_CNT_W'(1);
            end
        end
    end

    // Status registers, updated at input acceptance
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            frame_q    <= '0;
            line_q     <= '0;
            sof_err_q  <= 1'b0;
            prev_eol_q <= 1'b1;
        end else begin
            frame_q   <= frame_d;
            line_q    <= line_d;
            sof_err_q <= sof_err_d;
            if (in_fire) prev_eol_q <= s_axis_tlast;
        end
    end

    assign frame_count = frame_q;
    assign line_count  = line_q;
    assign sof_err     = sof_err_q;

endmodule

// File: tb/tb_filter_pixel_core.sv
// Directed bench for filter_pixel_core (narrow counters to reach wrap and
// saturation quickly). Honours FILTER_PIXEL_SKID_EN for expected latency.
module tb_filter_pixel_core;

    localparam int LCW = 3;
    localparam int FCW = 4;
`ifdef FILTER_PIXEL_SKID_EN
    localparam int   LAT  = 3;
    localparam logic SKID = 1'b1;
`else
    localparam int   LAT  = 2;
    localparam logic SKID = 1'b0;
`endif

    logic           ACLK, ARESET;
    logic [1:0]     cfg_mode;
    logic [7:0]     cfg_thresh;
    logic           cfg_clr_err;
    logic [23:0]    s_axis_tdata, m_axis_tdata;
    logic           s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
    logic           m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
    logic [FCW-1:0] frame_count;
    logic [LCW-1:0] line_count;
    logic           sof_err;

    typedef struct {
        logic [23:0] d;
        logic        u;
        logic        l;
        int          c;
    } obeat_t;

    obeat_t outq[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc   = 0;
    logic   rnd_en = 1'b0;
    logic   hold_v = 1'b0;
    logic [25:0] hold_q;

    filter_pixel_core #(
        .LINE_CNT_W    (LCW),
        .FRAME_CNT_W   (FCW),
        .DEFAULT_THRESH(8'h80)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .cfg_mode     (cfg_mode),
        .cfg_thresh   (cfg_thresh),
        .cfg_clr_err  (cfg_clr_err),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .frame_count  (frame_count),
        .line_count   (line_count),
        .sof_err      (sof_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor on the falling edge: log transfers, check stall stability
    always @(negedge ACLK) begin
        if (ARESET) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                chk("hold", 32'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}),
                    32'({1'b1, hold_q}));
            if (m_axis_tvalid && m_axis_tready)
                outq.push_back('{m_axis_tdata, m_axis_tuser, m_axis_tlast, cyc + 1});
            hold_v = m_axis_tvalid && !m_axis_tready;
            hold_q = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        end
    end

    // Random downstream backpressure when enabled
    initial forever begin
        @(posedge ACLK); #1;
        if (rnd_en) m_axis_tready = 1'($urandom_range(0, 1));
    end

    // Drive one beat from posedge+1; return the acceptance cycle
    task automatic send(input logic [23:0] d, input logic u, input logic l,
                        input logic clr, output int acc);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        cfg_clr_err   = clr;
        s_axis_tvalid = 1'b1;
        @(negedge ACLK);
        while (!s_axis_tready && n < 200) begin
            n++;
            @(negedge ACLK);
        end
        if (!s_axis_tready) chk("send_timeout", 32'(s_axis_tready), 32'd1);
        acc = cyc + 1;
        @(posedge ACLK); #1;
        s_axis_tvalid = 1'b0;
        cfg_clr_err   = 1'b0;
    endtask

    task automatic pop_out(output obeat_t b);
        int n = 0;
        while (outq.size() == 0 && n < 100) begin
            @(posedge ACLK); #1;
            n++;
        end
        chk("out_avail", 32'(outq.size() != 0), 32'd1);
        if (outq.size() != 0) b = outq.pop_front();
        else b = '{24'h0, 1'b0, 1'b0, 0};
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        chk({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
        chk({tag, "_tuser"},  32'(m_axis_tuser),  32'd0);
        chk({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
        chk({tag, "_frame"},  32'(frame_count),   32'd0);
        chk({tag, "_line"},   32'(line_count),    32'd0);
        chk({tag, "_err"},    32'(sof_err),       32'd0);
    endtask

    initial begin
        obeat_t      b;
        int          a, a0, a1, a2;
        logic [23:0] pix[64];
        logic [23:0] e;

        ARESET = 1'b1; cfg_mode = 2'd0; cfg_thresh = 8'h00; cfg_clr_err = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        #1;
        chk_reset("por");
        @(posedge ACLK); #1;
        ARESET = 1'b0;

        // Reset mid-stream with a stalled invert beat on the output
        cfg_mode = 2'd3; m_axis_tready = 1'b0;
        send(24'h123456, 1'b1, 1'b0, 1'b0, a);
        repeat (4) @(posedge ACLK);
        #1;
        chk("t1_valid",  32'(m_axis_tvalid), 32'd1);
        chk("t1_invert", 32'(m_axis_tdata),  32'hEDCBA9);
        chk("t1_frame",  32'(frame_count),   32'd1);
        chk("t1_rdy_lo", 32'(s_axis_tready), 32'(SKID));
        m_axis_tready = 1'b1; #1;
        chk("t1_rdy_hi", 32'(s_axis_tready), 32'd1);
        m_axis_tready = 1'b0; #1;
        ARESET = 1'b1; #1;
        chk_reset("t1_rst");
        @(posedge ACLK); #1;
        ARESET = 1'b0; m_axis_tready = 1'b1;
        outq.delete();
        send(24'h123456, 1'b0, 1'b0, 1'b0, a);
        pop_out(b);
        chk("t1_bypass", 32'(b.d), 32'h123456);
        chk("t1_lat", 32'(b.c - a), 32'(LAT));
        // Reset again while the previous beat was not EOL
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;

        // Grayscale
        cfg_mode = 2'd1;
        send(24'hFF0000, 1'b1, 1'b0, 1'b0, a0);
        send(24'h00FF00, 1'b0, 1'b0, 1'b0, a1);
        send(24'hFFFFFF, 1'b0, 1'b1, 1'b0, a2);
        chk("t2_b2b", 32'(a2 - a0), 32'd2);
        pop_out(b);
        chk("t2_red", 32'(b.d), 32'h4C4C4C);
        chk("t2_lat0", 32'(b.c - a0), 32'(LAT));
        chk("t2_user", 32'({b.u, b.l}), 32'b10);
        pop_out(b);
        chk("t2_green", 32'(b.d), 32'h959595);
        chk("t2_lat1", 32'(b.c - a1), 32'(LAT));
        pop_out(b);
        chk("t2_white", 32'(b.d), 32'hFFFFFF);
        chk("t2_lat2", 32'(b.c - a2), 32'(LAT));
        chk("t2_last", 32'({b.u, b.l}), 32'b01);
        chk("t2_frame", 32'(frame_count), 32'd1);
        chk("t2_line",  32'(line_count),  32'd1);
        chk("t2_err",   32'(sof_err),     32'd0);

        // Threshold, mid-frame threshold change deferred to next SOF
        cfg_mode = 2'd2; cfg_thresh = 8'h95;
        send(24'h00FF00, 1'b1, 1'b0, 1'b0, a);
        cfg_thresh = 8'h10;
        send(24'hFF0000, 1'b0, 1'b1, 1'b0, a);
        send(24'hFF0000, 1'b1, 1'b1, 1'b0, a);
        pop_out(b); chk("t3_eq_thresh", 32'(b.d), 32'hFFFFFF);
        pop_out(b); chk("t3_midframe",  32'(b.d), 32'h000000);
        pop_out(b); chk("t3_next_sof",  32'(b.d), 32'hFFFFFF);
        chk("t3_frame", 32'(frame_count), 32'd3);
        chk("t3_line",  32'(line_count),  32'd1);

        // Invert under random backpressure, 4 lines of 16
        cfg_mode = 2'd3; rnd_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pix[i] = 24'($urandom);
            send(pix[i], i == 0, (i % 16) == 15, 1'b0, a);
        end
        for (int i = 0; i < 64; i++) begin
            pop_out(b);
            e = ~pix[i];
            chk("t4_data", 32'(b.d), 32'(e));
            chk("t4_flags", 32'({b.u, b.l}), 32'({i == 0, (i % 16) == 15}));
        end
        rnd_en = 1'b0; m_axis_tready = 1'b1;
        chk("t4_line",  32'(line_count),  32'd4);
        chk("t4_frame", 32'(frame_count), 32'd4);

        // SOF mid-line error, set beats clear, lone clear
        cfg_mode = 2'd0;
        send(24'h000001, 1'b1, 1'b0, 1'b0, a);
        for (int k = 2; k <= 4; k++) send(24'(k), 1'b0, 1'b0, 1'b0, a);
        chk("t5_err_pre", 32'(sof_err), 32'd0);
        send(24'h000005, 1'b1, 1'b0, 1'b0, a);
        chk("t5_err_set", 32'(sof_err), 32'd1);
        send(24'h000006, 1'b0, 1'b0, 1'b0, a);
        send(24'h000007, 1'b1, 1'b0, 1'b1, a);
        chk("t5_set_wins", 32'(sof_err), 32'd1);
        cfg_clr_err = 1'b1;
        @(posedge ACLK); #1;
        cfg_clr_err = 1'b0;
        chk("t5_clr", 32'(sof_err), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            pop_out(b);
            chk("t5_bypass", 32'(b.d), 32'(k));
        end

        // Frame counter wrap and line counter saturation
        for (int k = 0; k < 8; k++) send(24'h0, 1'b1, 1'b1, 1'b0, a);
        chk("t6_err",      32'(sof_err),     32'd1);
        chk("t6_frame_max", 32'(frame_count), 32'hF);
        send(24'h0, 1'b1, 1'b1, 1'b0, a);
        chk("t6_wrap", 32'(frame_count), 32'd0);
        chk("t6_line_sof", 32'(line_count), 32'd1);
        for (int k = 0; k < 8; k++) send(24'h0, 1'b0, 1'b1, 1'b0, a);
        chk("t6_line_sat", 32'(line_count), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
